arb4_sched: RTL and testbench
=============================

ARB4_SCHED -- requirements
Module: arb4_sched

Interface
REQ-001 The block SHALL have parameter MAX_HOLD, default 8, giving the maximum consecutive grant cycles before forced release when another requester waits (legal range 1..15).
REQ-002 Port clk  input  1  rising-edge clock; all state SHALL update on its rising edge.
REQ-003 Port rst_n  input  1  reset; one clock, reset is asynchronous and active-low.
REQ-004 Port req  input  4  request lines, req[i] high = requester i wants the shared resource.
REQ-005 Port mode  input  1  0 = fixed priority (index 3 highest), 1 = round-robin.
REQ-006 Port gnt  output  4  one-hot grant, registered.
REQ-007 Port gnt_id  output  2  binary index of the granted requester, registered.
REQ-008 Port valid  output  1  high when any grant is active, registered.

Function
REQ-009 The block SHALL implement two states: IDLE (no grant) and GRANT (exactly one gnt bit high).
REQ-010 gnt SHALL be zero or one-hot at all times; valid SHALL equal OR of gnt; gnt_id SHALL equal the index of the set gnt bit, 2'b00 when valid=0.
REQ-011 IDLE: if req != 0 at a rising edge, the block SHALL enter GRANT at that edge with the winner granted (one-cycle latency req->gnt); else remain IDLE.
REQ-012 Fixed mode winner: highest set index of the candidate vector (3 > 2 > 1 > 0).
REQ-013 Round-robin winner: first set bit of the candidate vector searching ascending from pointer ptr, wrapping 3->0.
REQ-014 ptr (2 bits) SHALL reset to 0 and, on every new grant, load (winning index + 1) mod 4; ptr SHALL update in both modes.
REQ-015 hold counter hcnt (4 bits) SHALL load 1 on every new grant and increment each GRANT cycle, saturating at MAX_HOLD.
REQ-016 GRANT is held while req[owner]=1 and not (hcnt == MAX_HOLD and any other req bit set).
REQ-017 Release occurs at an edge where req[owner]=0 (normal release) or hcnt == MAX_HOLD with another req bit set (forced release).
REQ-018 On release, candidates SHALL be req with the owner bit masked; if nonzero, the winner SHALL be granted at the same edge (zero dead cycles, hcnt reloads 1); if zero, go to IDLE with gnt=0.
REQ-019 With the owner as sole requester, the grant SHALL persist indefinitely; hcnt saturates at MAX_HOLD.
REQ-020 mode SHALL be sampled only at arbitration edges; changing mode during GRANT SHALL not affect the current owner.
REQ-021 Requests arriving or dropping on non-owner lines during GRANT SHALL have no effect until the next arbitration edge.

Reset
REQ-022 rst_n low SHALL immediately (without clk) force gnt=0000, gnt_id=00, valid=0, state IDLE, ptr=0, hcnt=0.
REQ-023 Reset asserted mid-grant SHALL abort the grant; after rst_n rises the first edge with req != 0 SHALL arbitrate as from power-up (ptr=0).
REQ-024 Release of rst_n SHALL take effect only at clock edges; no grant SHALL appear before the first rising edge with rst_n high.

Verification
REQ-025 mode=0, req=0110 from IDLE -> next edge gnt=0100, gnt_id=10, valid=1; drop req[2] -> next edge gnt=0010, gnt_id=01.
REQ-026 mode=1 after reset, req=1111 held, MAX_HOLD=8 -> grant order 0,1,2,3,0 each lasting exactly 8 cycles with no gap.
REQ-027 mode=1, req=0001 only for 20 cycles -> gnt=0001 continuous, valid=1, hcnt saturated at 8; then req=0000 -> next edge valid=0, gnt_id=00.
REQ-028 mode=0, req=1001 held, MAX_HOLD=2 -> gnt alternates 1000 (2 cycles), 0001 (2 cycles), repeating.
REQ-029 rst_n pulled low between edges while gnt=0100 -> gnt=0000, valid=0 immediately; rst_n high, mode=1, req=0110 -> next edge gnt=0010.
REQ-030 All scenarios: every cycle check gnt is zero or one-hot and gnt_id/valid consistent with gnt.

Source files
------------

// File: rtl/arb4_sched.sv
// Four-way request arbiter with fixed-priority or round-robin selection and a
// hold limit that forces the owner to yield when someone else is waiting.
module arb4_sched #(
    parameter int MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic       mode,
    output logic [3:0] gnt,
    output logic [1:0] gnt_id,
    output logic       valid
);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    localparam logic [3:0] HoldMax = 4'(MAX_HOLD);

    state_t     state_q;
    logic [3:0] gnt_q;
    logic [1:0] gnt_id_q;
    logic       valid_q;
    logic [1:0] ptr_q;
    logic [3:0] hcnt_q;

    logic       ownerReq;
    logic       othersReq;
    logic       relNow;
    logic       arbitrate;
    logic [3:0] candidates;
    logic [1:0] winner;

    // Highest set index wins; index 3 has top priority.
    function automatic logic [1:0] pickFixed(input logic [3:0] c);
        logic [1:0] w;
        w = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (c[i]) w = 2'(i);
        end
        return w;
    endfunction

    // Scan downward so the last hit is the first set bit at or after the pointer.
    function automatic logic [1:0] pickRr(input logic [3:0] c, input logic [1:0] p);
        logic [1:0] w;
        logic [1:0] idx;
        w = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            idx = p + 2'(k);
            if (c[idx]) w = idx;
        end
        return w;
    endfunction

    always_comb begin
        ownerReq   = |(req & gnt_q);
        othersReq  = |(req & ~gnt_q);
        relNow     = (state_q == GRANT) && (!ownerReq || ((hcnt_q == HoldMax) && othersReq));
        arbitrate  = (state_q == IDLE) || relNow;
        candidates = (state_q == IDLE) ? req : (req & ~gnt_q);
        winner     = mode ? pickRr(candidates, ptr_q) : pickFixed(candidates);
    end

    // Arbitration edges hand the grant straight to the next winner, so a
    // release with other requesters pending never leaves a dead cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            gnt_q    <= 4'b0000;
            gnt_id_q <= 2'd0;
            valid_q  <= 1'b0;
            ptr_q    <= 2'd0;
            hcnt_q   <= 4'd0;
        end else if (arbitrate) begin
            if (|candidates) begin
                state_q  <= GRANT;
                gnt_q    <= 4'b0001 << winner;
                gnt_id_q <= winner;
                valid_q  <= 1'b1;
                ptr_q    <= winner + 2'd1;
                hcnt_q   <= 4'd1;
            end else begin
                state_q  <= IDLE;
                gnt_q    <= 4'b0000;
                gnt_id_q <= 2'd0;
                valid_q  <= 1'b0;
                hcnt_q   <= 4'd0;
            end
        end else if ((state_q == GRANT) && (hcnt_q != HoldMax)) begin
            hcnt_q <= hcnt_q + 4'd1;
        end
    end

    assign gnt    = gnt_q;
    assign gnt_id = gnt_id_q;
    assign valid  = valid_q;

endmodule

// File: tb/tb_arb4_sched.sv
// Directed scoreboard bench for arb4_sched: a MAX_HOLD=8 instance and a
// MAX_HOLD=2 instance share stimulus; expected grants are queued per step.
module tb_arb4_sched;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       mode;
    logic [3:0] req;

    logic [3:0] gnt8;
    logic [1:0] id8;
    logic       valid8;
    logic [3:0] gnt2;
    logic [1:0] id2;
    logic       valid2;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string      tag;
        bit         onDut2;
        logic [3:0] gnt;
    } exp_t;

    exp_t sbq[$];

    arb4_sched #(.MAX_HOLD(8)) dut8 (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req),
        .mode   (mode),
        .gnt    (gnt8),
        .gnt_id (id8),
        .valid  (valid8)
    );

    arb4_sched #(.MAX_HOLD(2)) dut2 (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req),
        .mode   (mode),
        .gnt    (gnt2),
        .gnt_id (id2),
        .valid  (valid2)
    );

    always #5 clk = ~clk;

    function automatic logic [1:0] idxOf(input logic [3:0] g);
        case (g)
            4'b0010: return 2'd1;
            4'b0100: return 2'd2;
            4'b1000: return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

    task automatic checkVal(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput();
        exp_t e;
        if (sbq.size() == 0) begin
            total++;
            bad++;
            $error("[TB] FAIL scoreboard_empty: observed=0 expected=1");
        end else begin
            e = sbq.pop_front();
            if (e.onDut2) begin
                checkVal({e.tag, "_gnt"}, gnt2, e.gnt);
                checkVal({e.tag, "_id"}, id2, idxOf(e.gnt));
                checkVal({e.tag, "_valid"}, valid2, |e.gnt);
            end else begin
                checkVal({e.tag, "_gnt"}, gnt8, e.gnt);
                checkVal({e.tag, "_id"}, id8, idxOf(e.gnt));
                checkVal({e.tag, "_valid"}, valid8, |e.gnt);
            end
        end
    endtask

    task automatic applyStimulus(input logic [3:0] r, input logic m, input logic [3:0] e,
                                 input bit onD2, input string tag);
        req  = r;
        mode = m;
        sbq.push_back('{tag, onD2, e});
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    task automatic pulseReset();
        @(negedge clk);
        rst_n = 1'b0;
        req   = 4'b0000;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Structural invariants on both instances, sampled mid-cycle.
    always @(negedge clk) begin
        checkVal("inv8_onehot", 8'($onehot0(gnt8)), 8'd1);
        checkVal("inv8_valid", valid8, |gnt8);
        checkVal("inv8_id", id8, idxOf(gnt8));
        checkVal("inv2_onehot", 8'($onehot0(gnt2)), 8'd1);
        checkVal("inv2_valid", valid2, |gnt2);
        checkVal("inv2_id", id2, idxOf(gnt2));
    end

    initial begin
        logic [3:0] e;
        rst_n = 1'b0;
        req   = 4'b0000;
        mode  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkVal("rst_gnt", gnt8, 8'h0);
        checkVal("rst_id", id8, 8'h0);
        checkVal("rst_valid", valid8, 8'h0);
        checkVal("rst_ptr", dut8.ptr_q, 8'h0);
        checkVal("rst_hcnt", dut8.hcnt_q, 8'h0);
        @(negedge clk);
        rst_n = 1'b1;

        applyStimulus(4'b0110, 1'b0, 4'b0100, 1'b0, "fix_0110");
        applyStimulus(4'b0010, 1'b0, 4'b0010, 1'b0, "fix_drop2");
        applyStimulus(4'b0111, 1'b1, 4'b0010, 1'b0, "hold_ignore");
        applyStimulus(4'b0101, 1'b1, 4'b0100, 1'b0, "rr_after1");

        // Asynchronous reset while requester 2 owns the grant.
        #2;
        rst_n = 1'b0;
        req   = 4'b0110;
        mode  = 1'b1;
        #1;
        checkVal("async_gnt", gnt8, 8'h0);
        checkVal("async_valid", valid8, 8'h0);
        checkVal("async_id", id8, 8'h0);
        @(posedge clk);
        #1;
        checkVal("rst_low_edge_gnt", gnt8, 8'h0);
        checkVal("rst_low_edge_ptr", dut8.ptr_q, 8'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkVal("rst_rel_nogrant", gnt8, 8'h0);
        applyStimulus(4'b0110, 1'b1, 4'b0010, 1'b0, "rr_after_rst");
        applyStimulus(4'b0000, 1'b1, 4'b0000, 1'b0, "to_idle");

        for (int n = 0; n < 20; n++) begin
            applyStimulus(4'b0001, 1'b1, 4'b0001, 1'b0, "solo");
        end
        checkVal("solo_hcnt_sat", dut8.hcnt_q, 8'd8);
        applyStimulus(4'b0000, 1'b1, 4'b0000, 1'b0, "solo_drop");

        pulseReset();
        for (int n = 1; n <= 40; n++) begin
            e = 4'b0001 << (((n - 1) / 8) % 4);
            applyStimulus(4'b1111, 1'b1, e, 1'b0, "rr_1111");
        end

        pulseReset();
        for (int n = 1; n <= 12; n++) begin
            e = ((((n - 1) / 2) % 2) == 0) ? 4'b1000 : 4'b0001;
            applyStimulus(4'b1001, 1'b0, e, 1'b1, "fix_hold2");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
